// File: rtl/zx_ram_arbiter_pkg.sv
// Shared types for the Spectrum SDRAM port arbiter: FSM states and channel-index sizing.
package zx_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } arb_state_e;

    localparam int ARB_MAX_CH = 8;

    // Width of a channel index / round-robin pointer; never narrower than one bit.
    function automatic int clog2_ch(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/zx_ram_arbiter_if.sv
// Master-side request/grant bundle plus the single SDRAM port of the arbiter.
interface zx_ram_arbiter_if #(
    parameter int NCH = 4,
    parameter int AW  = 25,
    parameter int DW  = 8
);
    logic              rr_mode;
    logic [NCH-1:0]    lock;
    logic [NCH-1:0]    req;
    logic [NCH-1:0]    we;
    logic [NCH*AW-1:0] addr;
    logic [NCH*DW-1:0] din;
    logic [NCH-1:0]    gnt;
    logic [NCH-1:0]    ack;
    logic [DW-1:0]     dout;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_din;
    logic              mem_we;
    logic              mem_rd;
    logic [DW-1:0]     mem_dout;
    logic              mem_ack;
    logic              busy;

    modport master (
        output rr_mode, lock, req, we, addr, din, mem_dout, mem_ack,
        input  gnt, ack, dout, mem_addr, mem_din, mem_we, mem_rd, busy
    );

    modport slave (
        input  rr_mode, lock, req, we, addr, din, mem_dout, mem_ack,
        output gnt, ack, dout, mem_addr, mem_din, mem_we, mem_rd, busy
    );
endinterface

// File: rtl/zx_ram_arbiter_rr_pick.sv
// Combinational winner select: locked requesters first, then fixed or round-robin order.
// Zero latency; no state, no backpressure.
module arb_rr_pick
    import zx_mem_pkg::*;
#(
    parameter int NCH = 4,
    localparam int PW = clog2_ch(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [NCH-1:0] lock,
    input  logic [PW-1:0]  ptr,
    input  logic           rr,
    output logic           valid,
    output logic [PW-1:0]  idx
);

    logic [NCH-1:0] locked;
    logic           found;

    assign locked = req & lock;

    always_comb begin
        valid = |req;
        idx   = '0;
        found = 1'b0;
        if (|locked) begin
            for (int i = 0; i < NCH; i++) begin
                if (!found && locked[i]) begin
                    idx   = PW'(i);
                    found = 1'b1;
                end
            end
        end else if (!rr) begin
            for (int i = 0; i < NCH; i++) begin
                if (!found && req[i]) begin
                    idx   = PW'(i);
                    found = 1'b1;
                end
            end
        end else begin
            // Scan starts at ptr and wraps, so the last served channel goes to the back.
            for (int i = 0; i < NCH; i++) begin
                if (!found && req[(int'(ptr) + i) % NCH]) begin
                    idx   = PW'((int'(ptr) + i) % NCH);
                    found = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/zx_ram_arbiter.sv
// N-channel request/grant/ack arbiter onto the 8-bit SDRAM port; latency 3+k cycles (k = strobe to mem_ack).
// Masters hold req until their ack; the memory paces the arbiter through mem_ack.
module zx_ram_arbiter
    import zx_mem_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int AW         = 25,
    parameter int DW         = 8,
    parameter bit RR_DEFAULT = 1'b0
) (
    input  logic            clk_sys,
    input  logic            cold_reset,
    zx_ram_arbiter_if.slave bus
);

    localparam int PW = clog2_ch(NCH > ARB_MAX_CH ? ARB_MAX_CH : NCH);
    localparam logic [NCH-1:0] GNT_ONE = NCH'(1);

    arb_state_e     state;
    logic [PW-1:0]  win;
    logic [PW-1:0]  rr_ptr;
    logic           h_we;
    logic           h_lock;
    logic           mode_q;
    logic [NCH-1:0] gnt_r;
    logic [NCH-1:0] ack_r;
    logic           mem_we_r;
    logic           mem_rd_r;
    logic           busy_r;
    logic [AW-1:0]  mem_addr_r;
    logic [DW-1:0]  mem_din_r;
    logic [DW-1:0]  dout_r;

    logic           pick_vld;
    logic [PW-1:0]  pick_idx;

    arb_rr_pick #(.NCH(NCH)) u_pick (
        .req   (bus.req),
        .lock  (bus.lock),
        .ptr   (rr_ptr),
        .rr    (bus.rr_mode),
        .valid (pick_vld),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk_sys or posedge cold_reset) begin
        if (cold_reset) begin
            state      <= IDLE;
            win        <= '0;
            rr_ptr     <= '0;
            h_we       <= 1'b0;
            h_lock     <= 1'b0;
            mode_q     <= RR_DEFAULT;
            gnt_r      <= '0;
            ack_r      <= '0;
            mem_we_r   <= 1'b0;
            mem_rd_r   <= 1'b0;
            busy_r     <= 1'b0;
            mem_addr_r <= '0;
            mem_din_r  <= '0;
            dout_r     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    mode_q <= bus.rr_mode;
                    if (pick_vld) begin
                        // mem_addr/mem_din double as the holding registers for the transaction.
                        win        <= pick_idx;
                        h_we       <= bus.we[pick_idx];
                        h_lock     <= bus.lock[pick_idx];
                        mem_addr_r <= bus.addr[int'(pick_idx)*AW +: AW];
                        mem_din_r  <= bus.din[int'(pick_idx)*DW +: DW];
                        gnt_r      <= GNT_ONE << pick_idx;
                        mem_we_r   <= bus.we[pick_idx];
                        mem_rd_r   <= !bus.we[pick_idx];
                        busy_r     <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_we_r <= 1'b0;
                    mem_rd_r <= 1'b0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (bus.mem_ack) begin
                        if (!h_we) dout_r <= bus.mem_dout;
                        ack_r <= gnt_r;
                        state <= DONE;
                    end
                end
                DONE: begin
                    ack_r  <= '0;
                    gnt_r  <= '0;
                    busy_r <= 1'b0;
                    // Locked (DMA-style) wins must not disturb fairness among the others.
                    if (mode_q && !h_lock)
                        rr_ptr <= (win == PW'(NCH-1)) ? '0 : win + 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt      = gnt_r;
    assign bus.ack      = ack_r;
    assign bus.dout     = dout_r;
    assign bus.mem_addr = mem_addr_r;
    assign bus.mem_din  = mem_din_r;
    assign bus.mem_we   = mem_we_r;
    assign bus.mem_rd   = mem_rd_r;
    assign bus.busy     = busy_r;

endmodule

// File: tb/tb_zx_ram_arbiter.sv
// Self-checking bench: vector table plus hand sequences, scoreboard of expected transactions.
module tb_zx_ram_arbiter;

    localparam int NCH = 4;
    localparam int AW  = 25;
    localparam int DW  = 8;

    typedef struct {
        int             ch;
        logic           we;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  din;
        logic [DW-1:0]  dat;
    } exp_t;

    typedef struct {
        logic           rr;
        logic [NCH-1:0] lock;
        logic [NCH-1:0] req;
        logic [NCH-1:0] we;
        int             k;
        int             ch;
    } vec_t;

    logic clk;
    logic rst;
    int   cyc;
    int   total;
    int   bad;
    int   mem_k;
    int   pend;
    logic [DW-1:0] pend_dat;
    logic prev_strobe;
    exp_t sb[$];
    exp_t e;
    vec_t vt[12];

    zx_ram_arbiter_if #(.NCH(NCH), .AW(AW), .DW(DW)) bus ();

    zx_ram_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .RR_DEFAULT(1'b0)) dut (
        .clk_sys    (clk),
        .cold_reset (rst),
        .bus        (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    task automatic set_bus(input int base);
        for (int c = 0; c < NCH; c++) begin
            bus.addr[c*AW +: AW] = AW'(32'h1000 * c + base * 3 + c * 17);
            bus.din[c*DW +: DW]  = DW'(8'h40 + base + c);
        end
    endtask

    task automatic push_exp(input int ch);
        exp_t x;
        x.ch   = ch;
        x.we   = bus.we[ch];
        x.addr = bus.addr[ch*AW +: AW];
        x.din  = bus.din[ch*DW +: DW];
        x.dat  = mem_data(x.addr);
        sb.push_back(x);
    endtask

    task automatic wait_ack(input int t0, output int ch, output int lat);
        bit found = 1'b0;
        ch  = -1;
        lat = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (|bus.ack) begin
                found = 1'b1;
                lat   = cyc - t0 + 1;
                for (int c = 0; c < NCH; c++) if (bus.ack[c]) ch = c;
            end
        end
        check("ack_seen", found, 1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        sb.delete();
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    // Memory model: acks k cycles after a strobe, read data is a function of the address.
    initial begin
        bus.mem_ack  = 1'b0;
        bus.mem_dout = 8'hEE;
        pend = 0;
        pend_dat = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_ack  = 1'b0;
            bus.mem_dout = 8'hEE;
            if (rst) begin
                pend = 0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        bus.mem_ack  = 1'b1;
                        bus.mem_dout = pend_dat;
                    end
                end
                if (bus.mem_we || bus.mem_rd) begin
                    pend     = mem_k;
                    pend_dat = mem_data(bus.mem_addr);
                end
            end
        end
    end

    // Scoreboard monitor: strobes checked against the in-flight entry, acks pop it.
    initial begin
        prev_strobe = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.mem_we || bus.mem_rd) begin
                check("strobe_one_cycle", prev_strobe, 0);
                check("strobe_exclusive", bus.mem_we & bus.mem_rd, 0);
                check("strobe_expected", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    check("strobe_addr", bus.mem_addr, sb[0].addr);
                    check("strobe_we", bus.mem_we, sb[0].we);
                    if (sb[0].we) check("strobe_din", bus.mem_din, sb[0].din);
                end
            end
            prev_strobe = bus.mem_we | bus.mem_rd;
            if (|bus.ack) begin
                check("ack_expected", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("ack_channel", bus.ack, 4'b0001 << e.ch);
                    check("gnt_in_done", bus.gnt, 4'b0001 << e.ch);
                    if (!e.we) check("read_dout", bus.dout, e.dat);
                end
            end
        end
    end

    initial begin
        int ch, lat, t0;
        int cnt[NCH];
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        mem_k = 1;
        bus.rr_mode = 1'b0;
        bus.lock = '0;
        bus.req  = '0;
        bus.we   = '0;
        set_bus(0);

        #12;
        check("rst_gnt", bus.gnt, 0);
        check("rst_ack", bus.ack, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_mem_rd", bus.mem_rd, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_din", bus.mem_din, 0);
        check("rst_dout", bus.dout, 0);
        @(posedge clk);
        #2 rst = 1'b0;

        //            rr    lock     req      we       k  ch
        vt[0]  = '{1'b0, 4'b0000, 4'b1010, 4'b0000, 1, 1};
        vt[1]  = '{1'b0, 4'b0000, 4'b1100, 4'b1111, 2, 2};
        vt[2]  = '{1'b0, 4'b0100, 4'b1111, 4'b0000, 1, 2};
        vt[3]  = '{1'b1, 4'b0000, 4'b1111, 4'b0001, 1, 0};
        vt[4]  = '{1'b1, 4'b0000, 4'b1001, 4'b0000, 1, 3};
        vt[5]  = '{1'b1, 4'b0000, 4'b0110, 4'b0010, 2, 1};
        vt[6]  = '{1'b1, 4'b0000, 4'b0011, 4'b0000, 1, 0};
        vt[7]  = '{1'b1, 4'b1000, 4'b1010, 4'b0000, 1, 3};
        vt[8]  = '{1'b1, 4'b0000, 4'b1100, 4'b0000, 4, 2};
        vt[9]  = '{1'b0, 4'b0000, 4'b1000, 4'b1000, 1, 3};
        vt[10] = '{1'b1, 4'b0000, 4'b1001, 4'b0000, 1, 3};
        vt[11] = '{1'b1, 4'b0000, 4'b0011, 4'b0001, 3, 0};

        for (int v = 0; v < 12; v++) begin
            @(posedge clk);
            #1;
            mem_k       = vt[v].k;
            bus.rr_mode = vt[v].rr;
            bus.lock    = vt[v].lock;
            bus.we      = vt[v].we;
            set_bus(v + 1);
            bus.req     = vt[v].req;
            push_exp(vt[v].ch);
            t0 = cyc;
            wait_ack(t0, ch, lat);
            check($sformatf("vec%0d_winner", v), ch, vt[v].ch);
            check($sformatf("vec%0d_latency", v), lat, 3 + vt[v].k);
        end
        @(posedge clk);
        #1 bus.req = '0;
        bus.lock = '0;

        // Fixed priority with 1010 held: ch1 at cycle 4, ch3 four cycles later.
        @(posedge clk);
        #1;
        mem_k = 1;
        bus.rr_mode = 1'b0;
        bus.we  = 4'b0000;
        set_bus(20);
        bus.req = 4'b1010;
        push_exp(1);
        push_exp(3);
        t0 = cyc;
        wait_ack(t0, ch, lat);
        check("fixed_first_ch", ch, 1);
        check("fixed_first_lat", lat, 4);
        @(posedge clk);
        #1 bus.req = 4'b1000;
        wait_ack(t0, ch, lat);
        check("fixed_second_ch", ch, 3);
        check("fixed_second_lat", lat, 8);
        @(posedge clk);
        #1 bus.req = 4'b0000;

        // Round-robin fairness from a fresh pointer.
        do_reset();
        @(posedge clk);
        #1;
        bus.rr_mode = 1'b1;
        bus.we = 4'b0000;
        set_bus(30);
        for (int i = 0; i < 16; i++) push_exp(i % NCH);
        for (int c = 0; c < NCH; c++) cnt[c] = 0;
        bus.req = 4'b1111;
        t0 = cyc;
        for (int i = 0; i < 16; i++) begin
            wait_ack(t0, ch, lat);
            check($sformatf("rr_order%0d", i), ch, i % NCH);
            check($sformatf("rr_lat%0d", i), lat, 4 * (i + 1));
            if (ch >= 0) cnt[ch]++;
        end
        @(posedge clk);
        #1 bus.req = 4'b0000;
        for (int c = 0; c < NCH; c++) check($sformatf("rr_count_ch%0d", c), cnt[c], 4);

        // Move rr_ptr to 2, then lock channel 0 against 0111.
        @(posedge clk);
        #1;
        bus.req = 4'b0010;
        push_exp(1);
        t0 = cyc;
        wait_ack(t0, ch, lat);
        check("lock_setup_ch", ch, 1);
        @(posedge clk);
        #1;
        bus.lock = 4'b0001;
        bus.req  = 4'b0111;
        push_exp(0);
        push_exp(0);
        push_exp(0);
        push_exp(2);
        t0 = cyc;
        for (int i = 0; i < 3; i++) begin
            wait_ack(t0, ch, lat);
            check($sformatf("lock_win%0d", i), ch, 0);
        end
        @(posedge clk);
        #1 bus.lock = 4'b0000;
        wait_ack(t0, ch, lat);
        check("unlock_next_ch", ch, 2);
        @(posedge clk);
        #1 bus.req = 4'b0000;

        // Read data path: ch2 reads 0x170000 with k=3; dout survives a later write.
        @(posedge clk);
        #1;
        mem_k = 3;
        bus.rr_mode = 1'b0;
        bus.we = 4'b0000;
        bus.addr[2*AW +: AW] = 25'h17_0000;
        bus.req = 4'b0100;
        push_exp(2);
        t0 = cyc;
        wait_ack(t0, ch, lat);
        check("read_ch", ch, 2);
        check("read_lat", lat, 6);
        check("read_dout_a5", bus.dout, 8'hA5);
        @(posedge clk);
        #1;
        mem_k = 1;
        bus.we  = 4'b0001;
        bus.req = 4'b0001;
        push_exp(0);
        t0 = cyc;
        wait_ack(t0, ch, lat);
        check("write_after_read_ch", ch, 0);
        check("dout_held_after_write", bus.dout, 8'hA5);
        @(posedge clk);
        #1 bus.req = 4'b0000;

        // Async reset in WAIT abandons the read; the held request restarts afterwards.
        @(posedge clk);
        #1;
        mem_k = 5;
        bus.we  = 4'b0000;
        set_bus(40);
        bus.req = 4'b0010;
        push_exp(1);
        @(posedge clk);
        @(posedge clk);
        #2;
        check("wait_busy", bus.busy, 1);
        check("wait_gnt", bus.gnt, 4'b0010);
        #1 rst = 1'b1;
        sb.delete();
        #1;
        check("arst_gnt", bus.gnt, 0);
        check("arst_mem_rd", bus.mem_rd, 0);
        check("arst_busy", bus.busy, 0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        push_exp(1);
        t0 = cyc;
        wait_ack(t0, ch, lat);
        check("restart_ch", ch, 1);
        check("restart_lat", lat, 8);
        @(posedge clk);
        #1 bus.req = 4'b0000;

        // One-cycle request pulse is still served with the latched write data.
        @(posedge clk);
        #1;
        mem_k = 1;
        bus.we = 4'b0010;
        bus.din[1*DW +: DW] = 8'h3C;
        bus.req = 4'b0010;
        push_exp(1);
        t0 = cyc;
        @(posedge clk);
        #1;
        bus.req = 4'b0000;
        bus.we  = 4'b0000;
        bus.din[1*DW +: DW] = 8'hFF;
        wait_ack(t0, ch, lat);
        check("pulse_ch", ch, 1);
        check("pulse_lat", lat, 4);

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        check("idle_busy", bus.busy, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
